updown_mod_counter: RTL and testbench

Parametrised up/down modulo counter with synchronous load, enable prescaler, wrap/saturate mode and terminal-count pulse. This is the next-generation replacement for the fixed 4-bit up counter. It serves as the general timebase/event counter for the sample designs and can be cascaded through `wrap`.

---
 rtl/updown_mod_counter_pkg.sv | 14 +
 rtl/updown_mod_counter_tick_prescaler.sv | 30 +++
 rtl/updown_mod_counter.sv | 80 ++++++++
 tb/tb_updown_mod_counter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter and its prescaler.
package updown_mod_counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    // Phase register width: $clog2(prescale), but never narrower than one bit.
    function automatic int phase_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/updown_mod_counter_tick_prescaler.sv
// Enable prescaler: tick fires on the enabled cycle that completes PRESCALE enabled cycles.
// tick is combinational from enable and phase; phase holds while enable is low.
module tick_prescaler
    import updown_mod_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int              PW   = phase_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = enable && (phase == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with clamped load, prescaled enable, wrap/saturate mode.
// Step and load land one cycle after the sampling edge; wrap is a one-cycle registered pulse.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter_out,
    output logic             wrap,
    output logic             at_limit
);

    generate
        if ((longint'(MODULUS) > (longint'(1) << WIDTH)) || (MODULUS < 2) || (PRESCALE < 1)) begin : g_bad_params
            $fatal(1, "updown_mod_counter: illegal MODULUS/WIDTH/PRESCALE combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic             tick;
    logic [WIDTH-1:0] load_clamped;
    logic             at_top;
    logic             at_bottom;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (load),
        .tick   (tick)
    );

    assign load_clamped = (load_value > TOP) ? TOP : load_value;
    assign at_top       = (counter_out == TOP);
    assign at_bottom    = (counter_out == '0);
    assign at_limit     = (up_down == DIR_UP) ? at_top : at_bottom;

    // wrap defaults low every cycle so it can only ever be a single-cycle pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter_out <= '0;
            wrap        <= 1'b0;
        end else if (load) begin
            counter_out <= load_clamped;
            wrap        <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (tick) begin
                if (up_down == DIR_UP) begin
                    if (!at_top) begin
                        counter_out <= counter_out + 1'b1;
                    end else if (SATURATE == MODE_WRAP) begin
                        counter_out <= '0;
                        wrap        <= 1'b1;
                    end
                end else begin
                    if (!at_bottom) begin
                        counter_out <= counter_out - 1'b1;
                    end else if (SATURATE == MODE_WRAP) begin
                        counter_out <= TOP;
                        wrap        <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: four counter variants (wrap, prescale-3, saturate, full-range modulus 16).
module tb_updown_mod_counter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // a: M10 P1 wrap, p: M10 P3 wrap, s: M10 P1 saturate, f: M16 P1 wrap
    logic       rst_a, en_a, ud_a, ld_a, wr_a, al_a;
    logic [3:0] lv_a, cnt_a;
    logic       rst_p, en_p, ud_p, ld_p, wr_p, al_p;
    logic [3:0] lv_p, cnt_p;
    logic       rst_s, en_s, ud_s, ld_s, wr_s, al_s;
    logic [3:0] lv_s, cnt_s;
    logic       rst_f, en_f, ud_f, ld_f, wr_f, al_f;
    logic [3:0] lv_f, cnt_f;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_a (
        .clock(clock), .reset(rst_a), .enable(en_a), .up_down(ud_a), .load(ld_a),
        .load_value(lv_a), .counter_out(cnt_a), .wrap(wr_a), .at_limit(al_a));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_p (
        .clock(clock), .reset(rst_p), .enable(en_p), .up_down(ud_p), .load(ld_p),
        .load_value(lv_p), .counter_out(cnt_p), .wrap(wr_p), .at_limit(al_p));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_s (
        .clock(clock), .reset(rst_s), .enable(en_s), .up_down(ud_s), .load(ld_s),
        .load_value(lv_s), .counter_out(cnt_s), .wrap(wr_s), .at_limit(al_s));
    updown_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(0)) u_f (
        .clock(clock), .reset(rst_f), .enable(en_f), .up_down(ud_f), .load(ld_f),
        .load_value(lv_f), .counter_out(cnt_f), .wrap(wr_f), .at_limit(al_f));

    int up_exp  [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_exp  [3]  = '{9, 8, 7};
    int pre_en  [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int pre_exp [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
    int rel_exp [3]  = '{0, 0, 1};

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; ud_a = 1'b1; ld_a = 1'b0; lv_a = '0;
        rst_p = 1'b1; en_p = 1'b0; ud_p = 1'b1; ld_p = 1'b0; lv_p = '0;
        rst_s = 1'b1; en_s = 1'b0; ud_s = 1'b1; ld_s = 1'b0; lv_s = '0;
        rst_f = 1'b1; en_f = 1'b0; ud_f = 1'b1; ld_f = 1'b0; lv_f = '0;

        // Reset and up count with wrap
        tick(); tick();
        check("rst_cnt", cnt_a, 0);
        check("rst_wrap", wr_a, 0);
        check("rst_atlim_up", al_a, 0);
        ud_a = 1'b0; #1;
        check("rst_atlim_dn", al_a, 1);
        rst_a = 1'b0; rst_p = 1'b0; rst_s = 1'b0; rst_f = 1'b0;
        ud_a = 1'b1; en_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("up_cnt", cnt_a, up_exp[i]);
            check("up_wrap", wr_a, (i == 9));
            check("up_atlim", al_a, (up_exp[i] == 9));
        end

        // Down wrap from 0
        en_a = 1'b0; rst_a = 1'b1;
        tick();
        rst_a = 1'b0; ud_a = 1'b0; #1;
        check("dn_atlim_rst", al_a, 1);
        en_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dn_cnt", cnt_a, dn_exp[i]);
            check("dn_wrap", wr_a, (i == 0));
        end

        // Load overrides enable, out-of-range load clamps
        ld_a = 1'b1; lv_a = 4'd7;
        tick();
        check("load7_cnt", cnt_a, 7);
        check("load7_wrap", wr_a, 0);
        lv_a = 4'd12;
        tick();
        check("load12_cnt", cnt_a, 9);
        check("load12_wrap", wr_a, 0);
        ld_a = 1'b0; en_a = 1'b0;
        tick();
        check("hold_cnt", cnt_a, 9);

        // Prescaler with an enable gap
        for (int i = 0; i < 11; i++) begin
            en_p = pre_en[i][0];
            tick();
            check("pre_cnt", cnt_p, pre_exp[i]);
            check("pre_wrap", wr_p, 0);
        end
        tick(); check("pre_a", cnt_p, 3);
        tick(); check("pre_b", cnt_p, 3);
        ld_p = 1'b1; lv_p = 4'd0;
        tick(); check("pre_load", cnt_p, 0);
        ld_p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pre_restart", cnt_p, rel_exp[i]);
        end

        // Reset during the wrap cycle, then mid-prescale
        en_p = 1'b0; ld_p = 1'b1; lv_p = 4'd0; ud_p = 1'b0;
        tick();
        ld_p = 1'b0; en_p = 1'b1;
        tick(); tick(); tick();
        check("pre_dnwrap_cnt", cnt_p, 9);
        check("pre_dnwrap_wrap", wr_p, 1);
        rst_p = 1'b1;
        tick();
        check("rstwrap_cnt", cnt_p, 0);
        check("rstwrap_wrap", wr_p, 0);
        rst_p = 1'b0; ud_p = 1'b1;
        tick(); tick();
        rst_p = 1'b1;
        tick();
        check("rstmid_cnt", cnt_p, 0);
        rst_p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_release", cnt_p, rel_exp[i]);
        end
        en_p = 1'b0;

        // Saturate at both bounds
        ld_s = 1'b1; lv_s = 4'd8;
        tick();
        check("sat_load", cnt_s, 8);
        ld_s = 1'b0; en_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("sat_up_cnt", cnt_s, 9);
            check("sat_up_wrap", wr_s, 0);
            check("sat_up_atlim", al_s, 1);
        end
        ud_s = 1'b0;
        tick();
        check("sat_flip", cnt_s, 8);
        ld_s = 1'b1; lv_s = 4'd0;
        tick();
        ld_s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sat_dn_cnt", cnt_s, 0);
            check("sat_dn_wrap", wr_s, 0);
            check("sat_dn_atlim", al_s, 1);
        end
        en_s = 1'b0;

        // Full-range modulus: natural overflow still pulses wrap
        ld_f = 1'b1; lv_f = 4'd15;
        tick();
        check("full_load", cnt_f, 15);
        check("full_atlim", al_f, 1);
        ld_f = 1'b0; en_f = 1'b1;
        tick();
        check("full_up_cnt", cnt_f, 0);
        check("full_up_wrap", wr_f, 1);
        tick();
        check("full_next_cnt", cnt_f, 1);
        check("full_next_wrap", wr_f, 0);
        ud_f = 1'b0;
        tick();
        check("full_dn_cnt", cnt_f, 0);
        check("full_dn_wrap", wr_f, 0);
        tick();
        check("full_dnwrap_cnt", cnt_f, 15);
        check("full_dnwrap_wrap", wr_f, 1);
        en_f = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
